// File: rtl/cmp_word_seq_pkg.sv
// Shared state encoding and nibble width for the nibble-serial word compare sequencer.
package cmp_word_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_nib_mux.sv
// Combinational nibble select of latched operands; in signed mode the top nibble's
// bit 3 is inverted on both sides so an unsigned nibble compare gives signed order.
import cmp_word_seq_pkg::*;

module cmp_nib_mux #(
  parameter int NIBBLES = 4
) (
  input  logic [NIB_W*NIBBLES-1:0]   xr,
  input  logic [NIB_W*NIBBLES-1:0]   yr,
  input  logic [$clog2(NIBBLES)-1:0] idx,
  input  logic                       sgn,
  input  logic                       msb,
  output logic [NIB_W-1:0]           a_nib,
  output logic [NIB_W-1:0]           b_nib
);

  localparam int IW = $clog2(NIBBLES);

  logic [NIB_W-1:0] a_sel, b_sel;
  logic [NIB_W-1:0] flip;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_sel = xr[i*NIB_W +: NIB_W];
        b_sel = yr[i*NIB_W +: NIB_W];
      end
    end
  end

  assign flip  = {sgn & msb, {(NIB_W-1){1'b0}}};
  assign a_nib = a_sel ^ flip;
  assign b_nib = b_sel ^ flip;

endmodule

// File: rtl/cmp_word_seq.sv
// Word compare sequencer: walks an external 4-bit comparator MS nibble first, stops on the
// first unequal nibble; k RUN cycles + 1 DONE cycle; start is ignored unless IDLE.
import cmp_word_seq_pkg::*;

module cmp_word_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     SIGNED,
  input  logic [NIB_W*NIBBLES-1:0] X,
  input  logic [NIB_W*NIBBLES-1:0] Y,
  output logic [NIB_W-1:0]         A_nib,
  output logic [NIB_W-1:0]         B_nib,
  output logic                     En_out,
  input  logic                     G_in,
  input  logic                     E_in,
  input  logic                     L_in,
  output logic                     busy,
  output logic                     done,
  output logic                     GT,
  output logic                     EQ,
  output logic                     LT,
  output logic                     ERR
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] IDX_MSB = IW'(NIBBLES - 1);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [W-1:0]    xr, yr;
  logic            sgn;
  logic            load;
  logic            gt_n, eq_n, lt_n, err_n;
  logic            run;
  logic [NIB_W-1:0] a_mux, b_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      xr    <= '0;
      yr    <= '0;
      sgn   <= 1'b0;
      GT    <= 1'b0;
      EQ    <= 1'b0;
      LT    <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      GT    <= gt_n;
      EQ    <= eq_n;
      LT    <= lt_n;
      ERR   <= err_n;
      if (load) begin
        xr  <= X;
        yr  <= Y;
        sgn <= SIGNED;
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    load    = 1'b0;
    gt_n    = GT;
    eq_n    = EQ;
    lt_n    = LT;
    err_n   = ERR;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          idx_n   = IDX_MSB;
          gt_n    = 1'b0;
          eq_n    = 1'b0;
          lt_n    = 1'b0;
          err_n   = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        // Anything other than exactly one flag is a comparator fault.
        case ({G_in, E_in, L_in})
          3'b100: begin
            gt_n    = 1'b1;
            state_n = DONE;
          end
          3'b001: begin
            lt_n    = 1'b1;
            state_n = DONE;
          end
          3'b010: begin
            if (idx == '0) begin
              eq_n    = 1'b1;
              state_n = DONE;
            end else begin
              idx_n = idx - 1'b1;
            end
          end
          default: begin
            err_n   = 1'b1;
            gt_n    = 1'b0;
            eq_n    = 1'b0;
            lt_n    = 1'b0;
            state_n = DONE;
          end
        endcase
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  cmp_nib_mux #(.NIBBLES(NIBBLES)) u_mux (
    .xr    (xr),
    .yr    (yr),
    .idx   (idx),
    .sgn   (sgn),
    .msb   (idx == IDX_MSB),
    .a_nib (a_mux),
    .b_nib (b_mux)
  );

  assign run    = (state == RUN);
  assign busy   = run;
  assign En_out = run;
  assign done   = (state == DONE);
  assign A_nib  = run ? a_mux : '0;
  assign B_nib  = run ? b_mux : '0;

endmodule

// File: tb/tb_cmp_word_seq.sv
// Directed bench: sequencer closed around a behavioural 4-bit comparator, with a fault override.
module tb_cmp_word_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [15:0] x, y;
  logic [3:0]  a_nib, b_nib;
  logic        en_out, g_in, e_in, l_in;
  logic        busy, done, gt, eq, lt, err;
  logic        force_bad;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [3:0] a_log [0:40];
  logic [3:0] b_log [0:40];

  always #5 clk = ~clk;

  assign g_in = force_bad | (a_nib > b_nib);
  assign e_in = force_bad | (a_nib == b_nib);
  assign l_in = ~force_bad & (a_nib < b_nib);

  cmp_word_seq #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .SIGNED (sgn),
    .X      (x),
    .Y      (y),
    .A_nib  (a_nib),
    .B_nib  (b_nib),
    .En_out (en_out),
    .G_in   (g_in),
    .E_in   (e_in),
    .L_in   (l_in),
    .busy   (busy),
    .done   (done),
    .GT     (gt),
    .EQ     (eq),
    .LT     (lt),
    .ERR    (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept edge; on return we sit in RUN cycle 1.
  task automatic do_start(input logic [15:0] xv, input logic [15:0] yv, input logic s);
    x = xv; y = yv; sgn = s; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns the cycle index (after the accept edge) in which done is seen.
  task automatic run_to_done(output int c);
    c = 1;
    while (!done && c < 40) begin
      a_log[c] = a_nib;
      b_log[c] = b_nib;
      step();
      c++;
    end
  endtask

  task automatic flags(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, gt, eq, lt, err}, {28'd0, exp});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; x = '0; y = '0; force_bad = 1'b0;
    #12;
    chk("rst_outs", {18'd0, busy, done, gt, eq, lt, err, en_out, a_nib, b_nib}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk("idle_outs", {18'd0, busy, done, gt, eq, lt, err, en_out, a_nib, b_nib}, 32'd0);

    // Equal operands: full walk, MS nibble first.
    do_start(16'h1234, 16'h1234, 1'b0);
    chk("eq_busy_en", {30'd0, busy, en_out}, 32'h3);
    run_to_done(cyc);
    chk("eq_done_cyc", cyc, 5);
    chk("eq_a_seq", {16'd0, a_log[1], a_log[2], a_log[3], a_log[4]}, 32'h1234);
    chk("eq_done_busy", {30'd0, done, busy}, 32'h2);
    flags("eq_flags", 4'b0100);
    step();
    chk("eq_after_idle", {28'd0, done, busy, en_out, eq}, 32'h1);

    // Unsigned 9 > 1 on the top nibble.
    do_start(16'h9000, 16'h1000, 1'b0);
    run_to_done(cyc);
    chk("ugt_done_cyc", cyc, 2);
    flags("ugt_flags", 4'b1000);
    step();

    // Signed: 0x9000 is negative.
    do_start(16'h9000, 16'h1000, 1'b1);
    run_to_done(cyc);
    chk("slt_done_cyc", cyc, 2);
    chk("slt_wire", {24'd0, a_log[1], b_log[1]}, 32'h19);
    flags("slt_flags", 4'b0010);
    step();

    // Difference only in the lowest nibble.
    do_start(16'h00A5, 16'h00A7, 1'b0);
    run_to_done(cyc);
    chk("low_lt_cyc", cyc, 5);
    flags("low_lt_flags", 4'b0010);
    step();
    do_start(16'h00A7, 16'h00A5, 1'b0);
    flags("clear_on_accept", 4'b0000);
    run_to_done(cyc);
    chk("low_gt_cyc", cyc, 5);
    flags("low_gt_flags", 4'b1000);
    step();

    // Comparator returns G and E together in the first RUN cycle.
    do_start(16'h1234, 16'h1234, 1'b0);
    force_bad = 1'b1;
    step();
    force_bad = 1'b0;
    chk("err_done", {31'd0, done}, 32'd1);
    flags("err_flags", 4'b0001);
    step();

    // Re-pulsed start during RUN and DONE is ignored.
    do_start(16'h1234, 16'h1234, 1'b0);
    x = 16'hFFFF; y = 16'h0000; start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_busy2", {31'd0, busy}, 32'd1);
    step();
    chk("ign_busy3", {31'd0, busy}, 32'd1);
    step();
    chk("ign_busy4", {31'd0, busy}, 32'd1);
    start = 1'b1;
    step();
    chk("ign_done5", {30'd0, done, busy}, 32'h2);
    flags("ign_flags", 4'b0100);
    step();
    start = 1'b0;
    chk("ign_no_restart", {30'd0, busy, done}, 32'd0);
    step();

    // Reset in the second RUN cycle aborts with no done.
    do_start(16'hFFFF, 16'hFFFF, 1'b0);
    step();
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_outs", {18'd0, busy, done, gt, eq, lt, err, en_out, a_nib, b_nib}, 32'd0);
    step();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) cyc++;
      step();
    end
    chk("abort_no_done", cyc, 0);
    do_start(16'hFFFF, 16'hFFFF, 1'b0);
    run_to_done(cyc);
    chk("post_rst_cyc", cyc, 5);
    flags("post_rst_flags", 4'b0100);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_word_seq.md
Name: cmp_word_seq

Overview:
- Sequencer that compares two wide operands by running the 4-bit magnitude comparator one nibble per cycle, most-significant nibble first.
- Sits around the comparator. Upstream: it drives the comparator's A, B and En inputs. Downstream: it consumes the comparator's G, E and L outputs and produces registered word-level GT/EQ/LT flags for the ALU flag path.
- Stops early on the first unequal nibble. Optional signed mode.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  request a compare; accepted only in IDLE
- SIGNED  input  1  1 = two's-complement compare; sampled with start
- X  input  W  operand X, latched on accepted start
- Y  input  W  operand Y, latched on accepted start
- A_nib  output  4  nibble of latched X driven to comparator A
- B_nib  output  4  nibble of latched Y driven to comparator B
- En_out  output  1  comparator enable
- G_in  input  1  comparator A>B
- E_in  input  1  comparator A=B
- L_in  input  1  comparator A<B
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, result valid
- GT  output  1  X>Y
- EQ  output  1  X=Y
- LT  output  1  X<Y
- ERR  output  1  comparator returned non-one-hot flags

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, operand regs=0. Outputs busy, done, GT, EQ, LT, ERR, En_out, A_nib, B_nib all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - En_out=0; A_nib=B_nib=0.
  - On start=1, at the clock edge: latch X, Y and SIGNED; clear GT/EQ/LT/ERR; set idx=NIBBLES-1; go to RUN.
- RUN:
  - busy=1, En_out=1.
  - A_nib = Xr[4*idx+3:4*idx]; B_nib = Yr[4*idx+3:4*idx].
  - Signed mode, idx=NIBBLES-1 only: bit 3 of both A_nib and B_nib is inverted (sign flip), so an unsigned nibble compare yields the signed order.
  - Comparator is combinational; G_in/E_in/L_in are sampled in the same cycle.
- Decision at each RUN edge, in priority order:
  - Flags not exactly one-hot (zero or more than one set): ERR=1, GT=EQ=LT=0, go to DONE.
  - G_in: GT=1, go to DONE.
  - L_in: LT=1, go to DONE.
  - E_in and idx==0: EQ=1, go to DONE.
  - E_in and idx>0: idx decrements, stay in RUN.
- DONE: done=1 for exactly one cycle, busy=0, En_out=0; unconditionally return to IDLE.
- Result flags GT/EQ/LT/ERR hold until the next accepted start or reset.
- Latency: k RUN cycles + 1 DONE cycle, where k = number of nibbles examined (1..NIBBLES). done is high in cycle k+1 after the start edge.
- start is ignored in RUN and DONE; there is no queueing. X/Y changes after acceptance have no effect.
- idx counter width = $clog2(NIBBLES). It never wraps, because decrement happens only when idx>0.
- Reset asserted mid-RUN aborts the compare with no done pulse; all outputs return to reset values.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Nibble width constant NIB_W=4.
- Natural sub-module: cmp_nib_mux, the combinational nibble select plus signed MSB bit-3 inversion. Inputs: Xr, Yr, idx, SIGNED, msb flag. Outputs: A_nib, B_nib.
- The 4-bit comparator stays an external instance, wired by the parent ALU.

Test Plan (NIBBLES=4, bench instantiates the 4-bit comparator in the loop):
- X=16'h1234, Y=16'h1234, SIGNED=0 -> 4 RUN cycles; A_nib sequence 1,2,3,4; done in cycle 5; EQ=1, GT=LT=ERR=0.
- X=16'h9000, Y=16'h1000, SIGNED=0 -> GT=1 after 1 RUN cycle, done in cycle 2. Same operands with SIGNED=1 -> LT=1 (A_nib=4'h1, B_nib=4'h9 on the wire).
- X=16'h00A5, Y=16'h00A7 -> LT=1, done in cycle 5. Then pulse start with X=16'h00A7, Y=16'h00A5 -> flags clear on accept, GT=1.
- Force G_in=E_in=1 in the first RUN cycle -> ERR=1, GT=EQ=LT=0, done in cycle 2.
- start re-pulsed in RUN with new X/Y -> ignored; result reflects the original operands; busy stays high until DONE.
- rst asserted in the 2nd RUN cycle of the X=Y=16'hFFFF compare -> all outputs 0 immediately, no done. A start after reset release completes normally with EQ=1.
